// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the decode-stage branch resolution unit.
//   - br_type codes as driven by the decoder
//   - FSM state encodings, kept as plain 2-bit constants for older tools
//   - flag_count helper used to check that the comparator flags are one-hot
package branch_resolve_pkg;

  // Branch type codes. Codes 101..111 are illegal and are never taken.
  localparam logic [2:0] BR_JMP = 3'b000;
  localparam logic [2:0] BR_BEQ = 3'b001;
  localparam logic [2:0] BR_BNE = 3'b010;
  localparam logic [2:0] BR_BGT = 3'b011;  // A > B
  localparam logic [2:0] BR_BLT = 3'b100;  // A < B

  // FSM state encodings
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_WAIT_OPS = 2'b01;
  localparam logic [1:0] ST_REDIRECT = 2'b10;
  localparam logic [1:0] ST_FLUSH    = 2'b11;

  // Number of comparator flags asserted (0..3).
  function automatic logic [1:0] flag_count(input logic gt, input logic lt, input logic eq);
    flag_count = {1'b0, gt} + {1'b0, lt} + {1'b0, eq};
  endfunction

endpackage

// File: rtl/branch_resolve_cond.sv
// Combinational branch condition evaluation.
// Ports:
//   br_type  in  3  branch type code (see branch_resolve_pkg)
//   cmp_gt   in  1  comparator flag, set when B > A
//   cmp_lt   in  1  comparator flag, set when A > B
//   cmp_eq   in  1  comparator flag, set when A == B
//   taken    out 1  branch resolves taken
//   flag_err out 1  conditional branch evaluated with non-one-hot flags
// Note the comparator's naming is from B's point of view: BGT (A>B) uses
// cmp_lt and BLT (A<B) uses cmp_gt.
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       cmp_gt,
  input  logic       cmp_lt,
  input  logic       cmp_eq,
  output logic       taken,
  output logic       flag_err
);

  logic conditional;

  always_comb begin
    taken       = 1'b0;
    flag_err    = 1'b0;
    conditional = 1'b0;
    case (br_type)
      BR_JMP: taken = 1'b1;
      BR_BEQ: begin conditional = 1'b1; taken = cmp_eq;  end
      BR_BNE: begin conditional = 1'b1; taken = !cmp_eq; end
      BR_BGT: begin conditional = 1'b1; taken = cmp_lt;  end
      BR_BLT: begin conditional = 1'b1; taken = cmp_gt;  end
      default: taken = 1'b0;
    endcase
    // Corrupt flags: never trust the comparator, fall through as not taken.
    if (conditional && (flag_count(cmp_gt, cmp_lt, cmp_eq) != 2'd1)) begin
      taken    = 1'b0;
      flag_err = 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Decode-stage branch resolution unit. Takes a decoded branch plus the
// comparator flags, stalls ID until forwarded operands are final, and with
// static predict-not-taken issues a PC redirect and IF/ID flush for every
// taken branch.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   br_valid/ready   branch handshake, transfer when both high in a cycle
//   br_type/target   branch type code and taken target
//   op_ready         comparator operands are final this cycle
//   cmp_gt/lt/eq     comparator flags
//   kill             older-instruction flush, cancels the branch in flight
//   stall_id         hold IF/ID while operands are pending
//   redirect_valid   one-cycle pulse, fetch loads redirect_pc
//   redirect_pc      latched branch target
//   flush_if/id      squash IF/ID instructions
//   taken_cnt        saturating count of taken branches since reset
//   cmp_err          sticky, flags were not one-hot at a conditional evaluation
//   state_dbg        current FSM state (debug visibility)
// Handshake: a branch is accepted on a rising edge where br_valid and
// br_ready are both high; br_ready depends only on state, never on br_valid,
// and br_valid while br_ready is low is ignored (ID keeps holding it).
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_type,
  input  logic [PC_W-1:0]  br_target,
  input  logic             op_ready,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             kill,
  output logic             stall_id,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             cmp_err,
  output logic [1:0]       state_dbg
);

  // Flush down-counter only needs to hold FLUSH_CYC-2.
  localparam int FCW = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC - 1) : 1;

  logic [1:0]      state;
  logic [2:0]      type_q;
  logic [PC_W-1:0] target_q;
  logic [FCW-1:0]  flush_cnt;

  logic [2:0] eval_type;
  logic       eval_en;
  logic       taken;
  logic       flag_err;

  // IDLE evaluates the incoming type (fast path); WAIT_OPS the latched one.
  assign eval_type = (state == ST_IDLE) ? br_type : type_q;
  assign eval_en   = !kill && op_ready &&
                     (((state == ST_IDLE) && br_valid) || (state == ST_WAIT_OPS));

  branch_cond u_cond (
    .br_type  (eval_type),
    .cmp_gt   (cmp_gt),
    .cmp_lt   (cmp_lt),
    .cmp_eq   (cmp_eq),
    .taken    (taken),
    .flag_err (flag_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      type_q    <= '0;
      target_q  <= '0;
      flush_cnt <= '0;
      taken_cnt <= '0;
      cmp_err   <= 1'b0;
    end else begin
      if (eval_en && flag_err) cmp_err <= 1'b1;
      // Counted at the evaluate edge so a killed branch never counts.
      if (eval_en && taken && (taken_cnt != {CNT_W{1'b1}}))
        taken_cnt <= taken_cnt + 1'b1;

      if (kill) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (br_valid) begin
              type_q   <= br_type;
              target_q <= br_target;
              if (!op_ready)   state <= ST_WAIT_OPS;
              else if (taken)  state <= ST_REDIRECT;
            end
          end
          ST_WAIT_OPS: begin
            if (op_ready) state <= taken ? ST_REDIRECT : ST_IDLE;
          end
          ST_REDIRECT: begin
            if (FLUSH_CYC > 1) begin
              state     <= ST_FLUSH;
              flush_cnt <= FCW'(FLUSH_CYC - 2);
            end else begin
              state <= ST_IDLE;
            end
          end
          default: begin  // ST_FLUSH
            if (flush_cnt == '0) state <= ST_IDLE;
            else                 flush_cnt <= flush_cnt - 1'b1;
          end
        endcase
      end
    end
  end

  assign br_ready       = (state == ST_IDLE);
  assign stall_id       = (state == ST_WAIT_OPS);
  assign redirect_valid = (state == ST_REDIRECT);
  assign redirect_pc    = target_q;
  assign flush_if       = (state == ST_REDIRECT) || (state == ST_FLUSH);
  assign flush_id       = flush_if;
  assign state_dbg      = state;

endmodule
